pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised, elastic pipeline-stage register. It is the next generation of the fixed-field stage registers between CPU stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Carries one opaque data bus and one control bus through a valid/ready handshake, with a 2-entry skid buffer so back-pressure costs no throughput.
- Adds a global hold (IM/DM stall), a synchronous flush, and bubble insertion with a parametrised idle control value (e.g. MemWrite=4'hf).
- All CPU stage boundaries are instantiated from this one block.

Parameters:
- DATA_W, 96, width of the data bus (PC, ALU result, rs2 data, etc.).
- CTRL_W, 14, width of the control bus (rd addr, MemRead, MemWrite, RegWrite, etc.).
- CTRL_IDLE, {CTRL_W{1'b0}}, control value presented on reset, flush or bubble.
- CNT_W, 32, width of the performance counters (used only with PERF_CNT_EN).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- hold  input  1  global stall (IM_stall | DM_stall); freezes all state
- flush  input  1  synchronous kill of all held entries
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept
- in_data  input  DATA_W  upstream data
- in_ctrl  input  CTRL_W  upstream control
- out_valid  output  1  downstream entry valid
- out_ready  input  1  downstream can accept
- out_data  output  DATA_W  registered data
- out_ctrl  output  CTRL_W  registered control, or CTRL_IDLE when not valid
- occupancy  output  2  entries held (0..2)
- stall_cnt  output  CNT_W  PERF_CNT_EN only
- bubble_cnt  output  CNT_W  PERF_CNT_EN only

Behaviour:
- Storage: main register (drives the outputs) plus one skid register.
- States: EMPTY (occupancy 0), ONE (main full), TWO (main and skid full). State is encoded as occupancy.
- Reset (async, rst=1): state EMPTY; main and skid data = 0, ctrl = CTRL_IDLE.
  - Outputs in reset: out_valid=0, out_data=0, out_ctrl=CTRL_IDLE, occupancy=0, in_ready=0.
  - in_ready=0 is a consequence of the hold-free rule below being masked by reset; it becomes 1 on the first cycle after reset deasserts.
  - Reset mid-transfer discards all entries.
- Handshake outputs:
  - in_ready = (state != TWO) & ~hold & ~rst.
  - out_valid = (state != EMPTY) & ~hold.
- Events:
  - acc = in_valid & in_ready.
  - deq = out_valid & out_ready.
  - in_ready does not depend combinationally on out_ready.
- Transitions on posedge clk, flush = 0:
  - EMPTY: acc → ONE, main ← in.
  - ONE: acc & deq → ONE, main ← in. acc & ~deq → TWO, skid ← in. deq only → EMPTY.
  - TWO: deq → ONE, main ← skid. acc is impossible (in_ready=0).
- Order is strictly FIFO. No entry is dropped or duplicated.
- Latency: an accepted entry is visible on out_* the cycle after acceptance when the stage was EMPTY, or when in ONE with a simultaneous deq.
- Throughput: 1 entry/cycle with out_ready held high.
- hold = 1: acc = deq = 0 and all registers keep their value. out_data and out_ctrl stay stable, but out_valid = 0.
- flush = 1: next state EMPTY; main and skid ctrl ← CTRL_IDLE, data ← 0. Any same-cycle acc or deq is discarded.
  - Flush has priority over hold.
  - Flush and deq in the same cycle: downstream has already sampled the entry; the upstream handshake is ignored.
- Bubble: out_ctrl = CTRL_IDLE whenever state == EMPTY, so downstream write enables are inert.
- occupancy is registered and equals the state encoding.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- When defined:
  - stall_cnt increments each cycle where (state != EMPTY) & (hold | ~out_ready).
  - bubble_cnt increments each cycle where state == EMPTY & ~hold.
  - Both counters saturate at all-ones, are cleared only by rst, and are unaffected by flush.
- When undefined: the stall_cnt and bubble_cnt ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then stream 0x1..0x8 with out_ready=1 → outputs appear one cycle later, in order, one per cycle; occupancy stays 1; no bubbles after the first entry.
- In ONE, drop out_ready for 3 cycles while in_valid=1 → occupancy 2 and in_ready=0 from the 2nd cycle. On out_ready=1, entries drain in order with none lost.
- hold=1 for 4 cycles in TWO with in_valid=out_ready=1 → state, out_data and occupancy are frozen, out_valid=0; after release, the sequence resumes unchanged.
- flush asserted in TWO with CTRL_IDLE=14'h0F00 → next cycle occupancy=0, out_valid=0, out_ctrl=14'h0F00, out_data=0; the next accepted entry flows normally.
- Assert rst asynchronously mid-stream → out_valid and occupancy go to 0 immediately, without waiting for a clock edge.
- With PIPE_STAGE_PERF_CNT_EN: 5 back-pressure cycles and 3 idle cycles → stall_cnt=5, bubble_cnt=3; with CNT_W=4 and 20 stalls, stall_cnt=4'hF.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline-stage register with a 2-entry skid buffer.
// One of these sits at each CPU stage boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
// It carries an opaque data bus and a control bus, and it adds three controls:
//   - global hold (IM/DM stall), which freezes all state
//   - synchronous flush, which kills every held entry
//   - bubble insertion, which forces CTRL_IDLE onto out_ctrl while the stage is empty
//
// Optional build macro: PIPE_STAGE_PERF_CNT_EN. Defining it adds the saturating
// stall_cnt and bubble_cnt performance counters and their ports.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are both
// high on the same side. valid never waits for ready. in_ready comes only from
// registered state, hold and rst, so it has no combinational path from out_ready.
// The skid register absorbs the one entry that can arrive while the stage fills.
// Because of that, back-pressure does not cost throughput.
module pipe_stage_skid #(
  parameter int                DATA_W    = 96,
  parameter int                CTRL_W    = 14,
  parameter logic [CTRL_W-1:0] CTRL_IDLE = {CTRL_W{1'b0}},
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_PERF_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic [1:0]        occupancy
);

  // The state encoding is the number of entries held, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              acc;
  logic              deq;

  // Handshake outputs and transfer events.
  // hold masks both sides, so no transfer is counted while the pipeline is stalled.
  always_comb begin
    in_ready  = (state != TWO) & ~hold & ~rst;
    out_valid = (state != EMPTY) & ~hold;
    acc       = in_valid & in_ready;
    deq       = out_valid & out_ready;
  end

  // Output drive.
  // An empty stage presents CTRL_IDLE so that downstream write enables stay inert.
  always_comb begin
    out_data  = main_data;
    out_ctrl  = (state == EMPTY) ? CTRL_IDLE : main_ctrl;
    occupancy = state;
  end

  // State and storage update.
  // Flush takes priority over hold and discards any same-cycle transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= CTRL_IDLE;
      skid_data <= '0;
      skid_ctrl <= CTRL_IDLE;
    end else if (flush) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= CTRL_IDLE;
      skid_data <= '0;
      skid_ctrl <= CTRL_IDLE;
    end else if (!hold) begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            state     <= ONE;
          end
        end
        ONE: begin
          if (acc && deq) begin
            // Pass-through: the new entry replaces the one leaving.
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end else if (acc) begin
            // The downstream side is blocked, so the new entry parks in the skid register.
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            state     <= TWO;
          end else if (deq) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a dequeue can happen.
          if (deq) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            state     <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic stall_evt;
  logic bubble_evt;

  // Counter events.
  // A stall is a held entry that cannot leave. A bubble is an empty, unstalled cycle.
  always_comb begin
    stall_evt  = (state != EMPTY) & (hold | ~out_ready);
    bubble_evt = (state == EMPTY) & ~hold;
  end

  // Saturating performance counters. Only rst clears them; flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (bubble_evt && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid.
// The DUT uses CTRL_IDLE=14'h0F00 and CNT_W=4.
// The counter checks are compiled only when PIPE_STAGE_PERF_CNT_EN is defined.
module tb_pipe_stage_skid;

  localparam int                DATA_W = 32;
  localparam int                CTRL_W = 14;
  localparam int                CNT_W  = 4;
  localparam logic [CTRL_W-1:0] IDLE   = 14'h0F00;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  // One table row is one clock cycle.
  // The row's inputs are applied, then outputs are checked #1 after the rising edge
  // while those inputs are still applied.
  typedef struct packed {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       hld;
    logic       fl;
    logic       ov;
    logic [7:0] ed;
    logic [1:0] occ;
    logic       ir;
    logic       cd;
  } vec_t;

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .CTRL_IDLE(IDLE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
`ifdef PIPE_STAGE_PERF_CNT_EN
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
`endif
    .occupancy (occupancy)
  );

  // The control value paired with each data word, so that ctrl tracks its own entry.
  function automatic logic [CTRL_W-1:0] ctrl_of(input logic [DATA_W-1:0] d);
    return d[CTRL_W-1:0] ^ 14'h1234;
  endfunction

  // Driver: apply one row's inputs.
  task automatic drive(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic hld, input logic fl);
    in_valid  = iv;
    in_data   = DATA_W'(d);
    in_ctrl   = ctrl_of(DATA_W'(d));
    out_ready = ordy;
    hold      = hld;
    flush     = fl;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++;
    if (occupancy !== 2'd0) begin failures++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++;
    if (out_data !== '0) begin failures++; $display("FAIL rst_out_data got %h want 0", out_data); end
    checks++;
    if (out_ctrl !== IDLE) begin failures++; $display("FAIL rst_out_ctrl got %h want %h", out_ctrl, IDLE); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] exp;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); end
      exp_q.push_back(DATA_W'(i));
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || occupancy !== 2'd1) begin
        failures++;
        $display("FAIL stream_valid_occ[%0d] got v=%b occ=%0d want v=1 occ=1", i, out_valid, occupancy);
      end
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL stream_queue[%0d] got empty queue want one entry", i);
      end else begin
        exp = exp_q.pop_front();
        checks++;
        if (out_data !== exp || out_ctrl !== ctrl_of(exp)) begin
          failures++;
          $display("FAIL stream_data[%0d] got %h/%h want %h/%h", i, out_data, out_ctrl, exp, ctrl_of(exp));
        end
      end
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== IDLE) begin
      failures++;
      $display("FAIL stream_drain got v=%b occ=%0d ctrl=%h want v=0 occ=0 ctrl=%h",
               out_valid, occupancy, out_ctrl, IDLE);
    end
  endtask

  task automatic test_backpressure();
    vec_t v[7];
    logic [CTRL_W-1:0] ec;
    //          iv    d      ordy  hld   fl    ov    ed     occ   ir    cd
    v = '{'{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 2'd1, 1'b1, 1'b1},
          '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2, 1'b0, 1'b1},
          '{1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2, 1'b0, 1'b1},
          '{1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd2, 1'b0, 1'b1},
          '{1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 2'd1, 1'b1, 1'b1},
          '{1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 2'd1, 1'b1, 1'b1},
          '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0}};
    for (int k = 0; k < 7; k++) begin
      drive(v[k].iv, v[k].d, v[k].ordy, v[k].hld, v[k].fl);
      @(posedge clk);
      #1;
      ec = (v[k].occ == 2'd0) ? IDLE : ctrl_of(DATA_W'(v[k].ed));
      checks++;
      if (out_valid !== v[k].ov || occupancy !== v[k].occ || in_ready !== v[k].ir) begin
        failures++;
        $display("FAIL bp_hs[%0d] got v=%b occ=%0d rdy=%b want v=%b occ=%0d rdy=%b",
                 k, out_valid, occupancy, in_ready, v[k].ov, v[k].occ, v[k].ir);
      end
      checks++;
      if (out_ctrl !== ec) begin failures++; $display("FAIL bp_ctrl[%0d] got %h want %h", k, out_ctrl, ec); end
      if (v[k].cd) begin
        checks++;
        if (out_data !== DATA_W'(v[k].ed)) begin
          failures++; $display("FAIL bp_data[%0d] got %h want %h", k, out_data, v[k].ed);
        end
      end
    end
  endtask

  task automatic test_hold();
    vec_t v[9];
    logic [CTRL_W-1:0] ec;
    //          iv    d      ordy  hld   fl    ov    ed     occ   ir    cd
    v = '{'{1'b1, 8'h21, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 2'd1, 1'b1, 1'b1},
          '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 2'd2, 1'b0, 1'b1},
          '{1'b1, 8'h23, 1'b1, 1'b1, 1'b0, 1'b0, 8'h21, 2'd2, 1'b0, 1'b1},
          '{1'b1, 8'h23, 1'b1, 1'b1, 1'b0, 1'b0, 8'h21, 2'd2, 1'b0, 1'b1},
          '{1'b1, 8'h23, 1'b1, 1'b1, 1'b0, 1'b0, 8'h21, 2'd2, 1'b0, 1'b1},
          '{1'b1, 8'h23, 1'b1, 1'b1, 1'b0, 1'b0, 8'h21, 2'd2, 1'b0, 1'b1},
          '{1'b1, 8'h23, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 2'd1, 1'b1, 1'b1},
          '{1'b1, 8'h23, 1'b1, 1'b0, 1'b0, 1'b1, 8'h23, 2'd1, 1'b1, 1'b1},
          '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0}};
    for (int k = 0; k < 9; k++) begin
      drive(v[k].iv, v[k].d, v[k].ordy, v[k].hld, v[k].fl);
      @(posedge clk);
      #1;
      ec = (v[k].occ == 2'd0) ? IDLE : ctrl_of(DATA_W'(v[k].ed));
      checks++;
      if (out_valid !== v[k].ov || occupancy !== v[k].occ || in_ready !== v[k].ir) begin
        failures++;
        $display("FAIL hold_hs[%0d] got v=%b occ=%0d rdy=%b want v=%b occ=%0d rdy=%b",
                 k, out_valid, occupancy, in_ready, v[k].ov, v[k].occ, v[k].ir);
      end
      checks++;
      if (out_ctrl !== ec) begin failures++; $display("FAIL hold_ctrl[%0d] got %h want %h", k, out_ctrl, ec); end
      if (v[k].cd) begin
        checks++;
        if (out_data !== DATA_W'(v[k].ed)) begin
          failures++; $display("FAIL hold_data[%0d] got %h want %h", k, out_data, v[k].ed);
        end
      end
    end
  endtask

  task automatic test_flush();
    vec_t v[10];
    logic [CTRL_W-1:0] ec;
    //          iv    d      ordy  hld   fl    ov    ed     occ   ir    cd
    v = '{'{1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b1, 8'h31, 2'd1, 1'b1, 1'b1},
          '{1'b1, 8'h32, 1'b0, 1'b0, 1'b0, 1'b1, 8'h31, 2'd2, 1'b0, 1'b1},
          '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1, 1'b1},
          '{1'b1, 8'h34, 1'b1, 1'b0, 1'b0, 1'b1, 8'h34, 2'd1, 1'b1, 1'b1},
          '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0},
          '{1'b1, 8'h35, 1'b0, 1'b0, 1'b0, 1'b1, 8'h35, 2'd1, 1'b1, 1'b1},
          '{1'b1, 8'h36, 1'b0, 1'b0, 1'b0, 1'b1, 8'h35, 2'd2, 1'b0, 1'b1},
          '{1'b1, 8'h37, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1},
          '{1'b1, 8'h37, 1'b1, 1'b0, 1'b0, 1'b1, 8'h37, 2'd1, 1'b1, 1'b1},
          '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0}};
    for (int k = 0; k < 10; k++) begin
      drive(v[k].iv, v[k].d, v[k].ordy, v[k].hld, v[k].fl);
      @(posedge clk);
      #1;
      ec = (v[k].occ == 2'd0) ? IDLE : ctrl_of(DATA_W'(v[k].ed));
      checks++;
      if (out_valid !== v[k].ov || occupancy !== v[k].occ || in_ready !== v[k].ir) begin
        failures++;
        $display("FAIL flush_hs[%0d] got v=%b occ=%0d rdy=%b want v=%b occ=%0d rdy=%b",
                 k, out_valid, occupancy, in_ready, v[k].ov, v[k].occ, v[k].ir);
      end
      checks++;
      if (out_ctrl !== ec) begin failures++; $display("FAIL flush_ctrl[%0d] got %h want %h", k, out_ctrl, ec); end
      if (v[k].cd) begin
        checks++;
        if (out_data !== DATA_W'(v[k].ed)) begin
          failures++; $display("FAIL flush_data[%0d] got %h want %h", k, out_data, v[k].ed);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b1, 8'h52, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (occupancy !== 2'd2) begin failures++; $display("FAIL arst_pre_occ got %0d want 2", occupancy); end
    // Assert reset between clock edges; it must act without an edge.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate got v=%b occ=%0d rdy=%b want v=0 occ=0 rdy=0",
               out_valid, occupancy, in_ready);
    end
    checks++;
    if (out_data !== '0 || out_ctrl !== IDLE) begin
      failures++; $display("FAIL arst_regs got %h/%h want 0/%h", out_data, out_ctrl, IDLE);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 8'h53, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== DATA_W'(8'h53) || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL arst_resume got v=%b d=%h occ=%0d want v=1 d=53 occ=1", out_valid, out_data, occupancy);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
  endtask

`ifdef PIPE_STAGE_PERF_CNT_EN
  task automatic test_perf_cnt();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
      failures++; $display("FAIL perf_reset got s=%0d b=%0d want 0/0", stall_cnt, bubble_cnt);
    end
    // Two idle edges, then a third idle edge that also accepts an entry.
    repeat (2) @(posedge clk);
    #1;
    drive(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // Five back-pressure edges.
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 4'd5 || bubble_cnt !== 4'd3) begin
      failures++; $display("FAIL perf_counts got s=%0d b=%0d want 5/3", stall_cnt, bubble_cnt);
    end
    // Fifteen more stall cycles make 20 in total, which saturates a 4-bit counter.
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 4'hF || bubble_cnt !== 4'd3) begin
      failures++; $display("FAIL perf_saturate got s=%0d b=%0d want 15/3", stall_cnt, bubble_cnt);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (stall_cnt !== 4'hF || bubble_cnt !== 4'd4) begin
      failures++; $display("FAIL perf_flush_keep got s=%0d b=%0d want 15/4", stall_cnt, bubble_cnt);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    hold      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_hold();
    test_flush();
    test_async_reset();
`ifdef PIPE_STAGE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
